coef_bank_ctrl: RTL
===================

COEF_BANK_CTRL -- requirements
Module: coef_bank_ctrl

Interface
REQ-001 The block SHALL have parameter NR_STAGES, default 32, the number of filter taps.
REQ-002 The block SHALL have parameter DWIDTH, default 16, the coefficient width.
REQ-003 The block SHALL have parameter CWIDTH, default NR_STAGES*DWIDTH, the flattened coefficient bus width.
REQ-004 The block SHALL have parameter AWIDTH, default 5, the coefficient address width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port cfg_req, input, 1, 4-phase configuration request.
REQ-008 The block SHALL have port cfg_ack, output, 1, 4-phase configuration acknowledge.
REQ-009 The block SHALL have port cfg_cmd, input, 1, command: 0 = write shadow coefficient, 1 = commit.
REQ-010 The block SHALL have port cfg_addr, input, [0:AWIDTH-1], tap index for a write.
REQ-011 The block SHALL have port cfg_data, input, signed [0:DWIDTH-1], coefficient value for a write.
REQ-012 The block SHALL have port in_req, input, 1, monitored filter input-port request.
REQ-013 The block SHALL have port in_ack, input, 1, monitored filter input-port acknowledge.
REQ-014 The block SHALL have port h_out, output, [0:CWIDTH-1], active coefficients; tap i on h_out[i*DWIDTH:(i+1)*DWIDTH-1].
REQ-015 The block SHALL have port swapped, output, 1, one-cycle pulse when a commit updates h_out.

Function
REQ-016 The block SHALL hold two banks of NR_STAGES signed DWIDTH coefficients: shadow (writable) and active (drives h_out).
REQ-017 The FSM SHALL have states IDLE, WAIT_SAFE, ACK.
REQ-018 In IDLE, an edge sampling cfg_req=1 and cfg_ack=0 with cfg_cmd=0 SHALL write cfg_data into shadow[cfg_addr] and enter ACK.
REQ-019 In IDLE, an edge sampling cfg_req=1 and cfg_ack=0 with cfg_cmd=1 SHALL enter WAIT_SAFE without touching either bank.
REQ-020 In WAIT_SAFE, the first edge sampling in_req=0 and in_ack=0 SHALL copy all shadow entries into active in one cycle, assert swapped for exactly that following cycle, and enter ACK.
REQ-021 While in_req or in_ack is 1, WAIT_SAFE SHALL hold indefinitely, and h_out SHALL NOT change.
REQ-022 cfg_ack SHALL be 1 exactly while in state ACK; ACK SHALL return to IDLE on the first edge sampling cfg_req=0.
REQ-023 Write latency SHALL be one edge from request acceptance to cfg_ack=1; commit latency SHALL be at least two edges.
REQ-024 Writes with cfg_addr >= NR_STAGES SHALL modify nothing, but SHALL still be acknowledged.
REQ-025 A commit SHALL leave shadow unchanged, so repeated commits are idempotent and partial rewrites are allowed.
REQ-026 h_out SHALL change only on a commit swap edge and on reset, never mid-handshake of the filter input port.
REQ-027 cfg_cmd, cfg_addr and cfg_data SHALL be sampled only on the acceptance edge; later changes SHALL be ignored.

Reset
REQ-028 With rst=1 at an edge, the block SHALL clear both banks to 0, set h_out=0, cfg_ack=0, swapped=0 and the state to IDLE.
REQ-029 Reset SHALL take priority over all other activity, including an abandoned WAIT_SAFE or ACK; no pending commit survives reset.
REQ-030 After reset, an asserted cfg_req SHALL be treated as a new request on the first edge with rst=0.

Verification
REQ-031 Write shadow[5]=1024, then commit with in_req=in_ack=0 -> h_out[80:95]=1024, swapped pulses once, and cfg_ack rises 2 edges after cfg_req.
REQ-032 Write shadow[3]=-7 without commit -> h_out stays all zero; write cfg_ack rises 1 edge after cfg_req and falls 1 edge after cfg_req drops.
REQ-033 Commit while in_req=1 for 10 cycles -> no swap and cfg_ack=0 for the whole window; the swap happens on the first edge after in_req=0 and in_ack=0.
REQ-034 Load the 32-tap low-pass set (taps 5..26: 1024,1024,1280,...,4352,4352,...,1024; others 0), then commit -> h_out matches bit-exactly, with tap 0 in bits [0:15].
REQ-035 Assert rst during WAIT_SAFE with a shadow loaded -> h_out=0, cfg_ack=0, swapped is never asserted, and a subsequent commit outputs all zeros.
REQ-036 Write with cfg_addr=31 and NR_STAGES=16 -> the write is acknowledged, no bank changes, and a commit leaves h_out unchanged.

Source files
------------

// File: rtl/coef_bank_ctrl.sv
// Double-buffered FIR coefficient bank: shadow taps are written over a 4-phase
// config handshake and copied to the active bank only while the filter input port is idle.
module coef_bank_ctrl #(
  parameter int NR_STAGES = 32,
  parameter int DWIDTH    = 16,
  parameter int CWIDTH    = NR_STAGES * DWIDTH,
  parameter int AWIDTH    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_req,
  output logic                     cfg_ack,
  input  logic                     cfg_cmd,
  input  logic        [0:AWIDTH-1] cfg_addr,
  input  logic signed [0:DWIDTH-1] cfg_data,
  input  logic                     in_req,
  input  logic                     in_ack,
  output logic        [0:CWIDTH-1] h_out,
  output logic                     swapped
);

  typedef enum logic [1:0] {IDLE, WAIT_SAFE, ACK} state_t;

  state_t                          state_q, state_d;
  logic [NR_STAGES-1:0][DWIDTH-1:0] shadow_q, shadow_d;
  logic [NR_STAGES-1:0][DWIDTH-1:0] active_q, active_d;
  logic                            cfg_ack_q, cfg_ack_d;
  logic                            swapped_q, swapped_d;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    swapped_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_req && !cfg_ack_q) begin
          if (cfg_cmd) begin
            state_d = WAIT_SAFE;
          end else begin
            // Out-of-range addresses match no tap, so they are acked but dropped.
            for (int i = 0; i < NR_STAGES; i++)
              if (32'(cfg_addr) == i) shadow_d[i] = cfg_data;
            state_d = ACK;
          end
        end
      end
      WAIT_SAFE: begin
        if (!in_req && !in_ack) begin
          active_d  = shadow_q;
          swapped_d = 1'b1;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (!cfg_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cfg_ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      cfg_ack_q <= 1'b0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cfg_ack_q <= cfg_ack_d;
      swapped_q <= swapped_d;
    end
  end

  assign cfg_ack = cfg_ack_q;
  assign swapped = swapped_q;

  for (genvar g = 0; g < NR_STAGES; g++) begin : g_tap
    assign h_out[g*DWIDTH +: DWIDTH] = active_q[g];
  end

endmodule
